// File: rtl/apb_cfg_sequencer_pkg.sv
// Shared definitions for the APB config sequencer: FSM encodings and default widths.
// The optional ACCESS timeout is enabled by defining APB_CFG_TIMEOUT_EN.
package apb_cfg_sequencer_pkg;

  localparam int unsigned REG_ADDR_W             = 8;
  localparam int unsigned REG_DATA_W             = 32;
  localparam int unsigned DEFAULT_FIFO_DEPTH     = 4;
  localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_SETUP  = 2'b01,
    ST_ACCESS = 2'b10,
    ST_TURN   = 2'b11
  } apb_state_e;

endpackage

// File: rtl/apb_cfg_sequencer_if.sv
// Command/response stream and APB bus bundle for the config sequencer.
// master = sequencer side, slave = host/config-slave side.
interface apb_cfg_sequencer_if #(
  parameter int unsigned ADDR_W = apb_cfg_sequencer_pkg::REG_ADDR_W,
  parameter int unsigned DATA_W = apb_cfg_sequencer_pkg::REG_DATA_W
) ();

  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;

  logic              rsp_valid;
  logic              rsp_ready;
  logic              rsp_write;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;

  logic [ADDR_W-1:0] PADDR;
  logic              PWRITE;
  logic              PSEL;
  logic              PENABLE;
  logic [DATA_W-1:0] PWDATA;
  logic [DATA_W-1:0] PRDATA;
  logic              PREADY;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready, PRDATA, PREADY,
    output cmd_ready, rsp_valid, rsp_write, rsp_rdata, rsp_err,
           PADDR, PWRITE, PSEL, PENABLE, PWDATA
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready, PRDATA, PREADY,
    input  cmd_ready, rsp_valid, rsp_write, rsp_rdata, rsp_err,
           PADDR, PWRITE, PSEL, PENABLE, PWDATA
  );

endinterface

// File: rtl/apb_cfg_sequencer_cmd_fifo.sv
// Synchronous command FIFO with registered full/empty flags.
// Pointers carry one extra bit so full and empty are distinguishable on wrap.
module apb_cfg_cmd_fifo #(
  parameter int unsigned WIDTH = 41,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty,
  output logic             o_empty_nxt_c
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wptr;
  logic [PW-1:0]    r_rptr;
  logic             r_full;
  logic             r_empty;
  logic [PW-1:0]    w_wptr_nxt;
  logic [PW-1:0]    w_rptr_nxt;
  logic             w_push;
  logic             w_pop;
  logic             w_full_nxt;
  logic             w_empty_nxt;

  // A push into a full FIFO is legal only when the head leaves in the same cycle
  assign w_push      = i_push && (!r_full || i_pop);
  assign w_pop       = i_pop && !r_empty;
  assign w_wptr_nxt  = r_wptr + PW'(w_push);
  assign w_rptr_nxt  = r_rptr + PW'(w_pop);
  assign w_empty_nxt = (w_wptr_nxt == w_rptr_nxt);
  assign w_full_nxt  = (w_wptr_nxt[AW] != w_rptr_nxt[AW]) &&
                       (w_wptr_nxt[AW-1:0] == w_rptr_nxt[AW-1:0]);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_full  <= 1'b0;
      r_empty <= 1'b1;
    end else begin
      r_wptr  <= w_wptr_nxt;
      r_rptr  <= w_rptr_nxt;
      r_full  <= w_full_nxt;
      r_empty <= w_empty_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr[AW-1:0]] <= i_wdata;
    end
  end

  assign o_rdata       = r_mem[r_rptr[AW-1:0]];
  assign o_full        = r_full;
  assign o_empty       = r_empty;
  assign o_empty_nxt_c = w_empty_nxt;

endmodule

// File: rtl/apb_cfg_sequencer.sv
// APB master that drains a command FIFO into the TPU config slave, one response per command.
// Define APB_CFG_TIMEOUT_EN to bound ACCESS at TIMEOUT_CYCLES and flag rsp_err on expiry.
module apb_cfg_sequencer
  import apb_cfg_sequencer_pkg::*;
#(
  parameter int unsigned ADDR_W         = REG_ADDR_W,
  parameter int unsigned DATA_W         = REG_DATA_W,
  parameter int unsigned FIFO_DEPTH     = DEFAULT_FIFO_DEPTH,
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic                PCLK,
  input  logic                reset,
  apb_cfg_sequencer_if.master bus,
  output logic                busy
);

  localparam int unsigned ENTRY_W = 1 + ADDR_W + DATA_W;

  logic [ENTRY_W-1:0] w_fifo_wdata;
  logic [ENTRY_W-1:0] w_fifo_rdata;
  logic               w_fifo_full;
  logic               w_fifo_empty;
  logic               w_fifo_empty_nxt;
  logic               w_push;
  logic               w_pop;
  logic               w_head_write;
  logic [ADDR_W-1:0]  w_head_addr;
  logic [DATA_W-1:0]  w_head_wdata;

  apb_state_e         r_state;
  apb_state_e         w_state_nxt;
  logic               r_psel,      w_psel_nxt;
  logic               r_penable,   w_penable_nxt;
  logic               r_pwrite,    w_pwrite_nxt;
  logic [ADDR_W-1:0]  r_paddr,     w_paddr_nxt;
  logic [DATA_W-1:0]  r_pwdata,    w_pwdata_nxt;
  logic               r_rsp_valid, w_rsp_valid_nxt;
  logic               r_rsp_write, w_rsp_write_nxt;
  logic [DATA_W-1:0]  r_rsp_rdata, w_rsp_rdata_nxt;
  logic               r_busy,      w_busy_nxt;

`ifdef APB_CFG_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] r_tmo_cnt, w_tmo_cnt_nxt;
  logic          r_rsp_err, w_rsp_err_nxt;
  logic          w_tmo_hit;
  assign w_tmo_hit = (r_tmo_cnt == TW'(TIMEOUT_CYCLES - 1));
`else
  logic [31:0] w_unused_tmo;
  assign w_unused_tmo = 32'(TIMEOUT_CYCLES);
`endif

  assign w_push       = bus.cmd_valid && !w_fifo_full;
  assign w_fifo_wdata = {bus.cmd_write, bus.cmd_addr, bus.cmd_wdata};
  assign {w_head_write, w_head_addr, w_head_wdata} = w_fifo_rdata;

  apb_cfg_cmd_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_cmd_fifo (
    .clk           (PCLK),
    .reset         (reset),
    .i_push        (w_push),
    .i_wdata       (w_fifo_wdata),
    .i_pop         (w_pop),
    .o_rdata       (w_fifo_rdata),
    .o_full        (w_fifo_full),
    .o_empty       (w_fifo_empty),
    .o_empty_nxt_c (w_fifo_empty_nxt)
  );

  // Next-state and next-output logic; all bus outputs are registered below
  always_comb begin
    w_state_nxt     = r_state;
    w_pop           = 1'b0;
    w_psel_nxt      = 1'b0;
    w_penable_nxt   = 1'b0;
    w_pwrite_nxt    = r_pwrite;
    w_paddr_nxt     = r_paddr;
    w_pwdata_nxt    = r_pwdata;
    w_rsp_valid_nxt = r_rsp_valid && !bus.rsp_ready;
    w_rsp_write_nxt = r_rsp_write;
    w_rsp_rdata_nxt = r_rsp_rdata;
`ifdef APB_CFG_TIMEOUT_EN
    w_rsp_err_nxt   = r_rsp_err;
    w_tmo_cnt_nxt   = r_tmo_cnt;
`endif
    case (r_state)
      ST_IDLE: begin
        if (!w_fifo_empty && !r_rsp_valid) begin
          w_pop        = 1'b1;
          w_state_nxt  = ST_SETUP;
          w_psel_nxt   = 1'b1;
          w_pwrite_nxt = w_head_write;
          w_paddr_nxt  = w_head_addr;
          w_pwdata_nxt = w_head_wdata;
`ifdef APB_CFG_TIMEOUT_EN
          w_tmo_cnt_nxt = '0;
`endif
        end
      end
      ST_SETUP: begin
        w_state_nxt   = ST_ACCESS;
        w_psel_nxt    = 1'b1;
        w_penable_nxt = 1'b1;
      end
      ST_ACCESS: begin
        w_psel_nxt    = 1'b1;
        w_penable_nxt = 1'b1;
        if (bus.PREADY) begin
          w_state_nxt     = ST_TURN;
          w_psel_nxt      = 1'b0;
          w_penable_nxt   = 1'b0;
          w_rsp_valid_nxt = 1'b1;
          w_rsp_write_nxt = r_pwrite;
          w_rsp_rdata_nxt = r_pwrite ? '0 : bus.PRDATA;
`ifdef APB_CFG_TIMEOUT_EN
          w_rsp_err_nxt   = 1'b0;
        end else if (w_tmo_hit) begin
          w_state_nxt     = ST_TURN;
          w_psel_nxt      = 1'b0;
          w_penable_nxt   = 1'b0;
          w_rsp_valid_nxt = 1'b1;
          w_rsp_write_nxt = r_pwrite;
          w_rsp_rdata_nxt = '0;
          w_rsp_err_nxt   = 1'b1;
        end else begin
          w_tmo_cnt_nxt   = r_tmo_cnt + TW'(1);
`endif
        end
      end
      ST_TURN: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign w_busy_nxt = !w_fifo_empty_nxt || (w_state_nxt != ST_IDLE);

  always_ff @(posedge PCLK) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_psel      <= 1'b0;
      r_penable   <= 1'b0;
      r_pwrite    <= 1'b0;
      r_paddr     <= '0;
      r_pwdata    <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_write <= 1'b0;
      r_rsp_rdata <= '0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_psel      <= w_psel_nxt;
      r_penable   <= w_penable_nxt;
      r_pwrite    <= w_pwrite_nxt;
      r_paddr     <= w_paddr_nxt;
      r_pwdata    <= w_pwdata_nxt;
      r_rsp_valid <= w_rsp_valid_nxt;
      r_rsp_write <= w_rsp_write_nxt;
      r_rsp_rdata <= w_rsp_rdata_nxt;
      r_busy      <= w_busy_nxt;
    end
  end

`ifdef APB_CFG_TIMEOUT_EN
  always_ff @(posedge PCLK) begin
    if (reset) begin
      r_tmo_cnt <= '0;
      r_rsp_err <= 1'b0;
    end else begin
      r_tmo_cnt <= w_tmo_cnt_nxt;
      r_rsp_err <= w_rsp_err_nxt;
    end
  end
  assign bus.rsp_err = r_rsp_err;
`else
  assign bus.rsp_err = 1'b0;
`endif

  assign bus.cmd_ready = !w_fifo_full;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_write = r_rsp_write;
  assign bus.rsp_rdata = r_rsp_rdata;
  assign bus.PSEL      = r_psel;
  assign bus.PENABLE   = r_penable;
  assign bus.PWRITE    = r_pwrite;
  assign bus.PADDR     = r_paddr;
  assign bus.PWDATA    = r_pwdata;
  assign busy          = r_busy;

endmodule

// File: tb/tb_apb_cfg_sequencer.sv
// Directed bench for apb_cfg_sequencer with a small APB register-file slave.
// Build with APB_CFG_TIMEOUT_EN defined to also exercise the ACCESS timeout.
module tb_apb_cfg_sequencer;

  localparam int unsigned AW  = 8;
  localparam int unsigned DW  = 32;
  localparam int unsigned TMO = 16;
  localparam logic [7:0] ADDR_ENABLES = 8'h10;

  logic clk;
  logic reset;
  logic busy;

  apb_cfg_sequencer_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  apb_cfg_sequencer #(
    .ADDR_W         (AW),
    .DATA_W         (DW),
    .FIFO_DEPTH     (4),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .PCLK  (clk),
    .reset (reset),
    .bus   (bus.master),
    .busy  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // APB slave: register file with a programmable number of wait states
  bit [31:0] slave_mem [256];
  int        acc_cnt = 0;
  int        wait_st = 0;
  bit        stall = 0;
  bit        force_ready = 0;

  always @(posedge clk) begin
    if (bus.PSEL && bus.PENABLE && bus.PREADY && bus.PWRITE) slave_mem[bus.PADDR] <= bus.PWDATA;
    if (bus.PSEL && bus.PENABLE && !bus.PREADY) acc_cnt <= acc_cnt + 1;
    else acc_cnt <= 0;
  end

  always_comb begin
    bus.PREADY = force_ready || (!stall && bus.PSEL && bus.PENABLE && (acc_cnt >= wait_st));
    bus.PRDATA = slave_mem[bus.PADDR];
  end

  // Bus monitor: cycle stamp of each SETUP and PSEL-low run preceding it
  int cyc = 0;
  int low_run = 0;
  int setup_q[$];
  int low_q[$];
  always @(negedge clk) begin
    if (bus.PSEL && !bus.PENABLE) begin
      setup_q.push_back(cyc);
      low_q.push_back(low_run);
      low_run = 0;
    end else if (!bus.PSEL) begin
      low_run++;
    end
    cyc++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic push_cmd(input bit wr, input logic [7:0] a, input logic [31:0] d);
    int g = 0;
    bus.cmd_valid = 1'b1;
    bus.cmd_write = wr;
    bus.cmd_addr  = a;
    bus.cmd_wdata = d;
    while (!bus.cmd_ready && g < 50) begin
      @(posedge clk); #1; g++;
    end
    check("push_accept", 32'(bus.cmd_ready), 32'd1);
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic do_cmd(input bit wr, input logic [7:0] a, input logic [31:0] d,
                        output int lat, output logic rw, output logic [31:0] rd, output logic re);
    push_cmd(wr, a, d);
    lat = 0;
    while (!bus.rsp_valid && lat < 100) begin
      @(posedge clk); #1; lat++;
    end
    rw = bus.rsp_write;
    rd = bus.rsp_rdata;
    re = bus.rsp_err;
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
  endtask

  typedef struct {
    bit          wr;
    logic [7:0]  addr;
    logic [31:0] wdata;
    int          wst;
    logic        exp_write;
    logic [31:0] exp_rdata;
    int          exp_lat;
  } vec_t;

  vec_t        vecs[7];
  int          lat;
  logic        rw;
  logic [31:0] rd;
  logic        re;
  int          n0;
  int          k;
  int          g;
  int          acc;
  bit          saw_psel;
  bit          saw_rsp;
  logic        exp_w[5];
  logic [31:0] exp_d[5];

  initial begin
    reset = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_wdata = '0;
    bus.rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_rsp_write", 32'(bus.rsp_write), 32'd0);
    check("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
    check("rst_rsp_err",   32'(bus.rsp_err), 32'd0);
    check("rst_psel",      32'(bus.PSEL), 32'd0);
    check("rst_penable",   32'(bus.PENABLE), 32'd0);
    check("rst_pwrite",    32'(bus.PWRITE), 32'd0);
    check("rst_paddr",     32'(bus.PADDR), 32'd0);
    check("rst_pwdata",    bus.PWDATA, 32'd0);
    check("rst_busy",      32'(busy), 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Single transfers: latency = 3 + slave wait states, counted from the accept edge
    vecs[0] = '{1'b1, ADDR_ENABLES, 32'h0000_000F, 0, 1'b1, 32'h0000_0000, 3};
    vecs[1] = '{1'b0, ADDR_ENABLES, 32'h0000_0000, 1, 1'b0, 32'h0000_000F, 4};
    vecs[2] = '{1'b1, 8'h20,        32'hA5A5_5A5A, 2, 1'b1, 32'h0000_0000, 5};
    vecs[3] = '{1'b0, 8'h20,        32'h0000_0000, 0, 1'b0, 32'hA5A5_5A5A, 3};
    vecs[4] = '{1'b0, 8'h30,        32'h0000_0000, 0, 1'b0, 32'h0000_0000, 3};
    vecs[5] = '{1'b1, 8'hFF,        32'hFFFF_FFFF, 1, 1'b1, 32'h0000_0000, 4};
    vecs[6] = '{1'b0, 8'hFF,        32'h0000_0000, 3, 1'b0, 32'hFFFF_FFFF, 6};
    for (int i = 0; i < 7; i++) begin
      wait_st = vecs[i].wst;
      do_cmd(vecs[i].wr, vecs[i].addr, vecs[i].wdata, lat, rw, rd, re);
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].exp_lat));
      check($sformatf("vec%0d_rsp_write", i), 32'(rw), 32'(vecs[i].exp_write));
      check($sformatf("vec%0d_rsp_rdata", i), rd, vecs[i].exp_rdata);
      check($sformatf("vec%0d_rsp_err", i), 32'(re), 32'd0);
    end
    repeat (2) @(posedge clk);
    #1;
    check("idle_busy", 32'(busy), 32'd0);

    // PREADY already high in SETUP must not shorten the transfer
    wait_st = 0;
    force_ready = 1'b1;
    do_cmd(1'b0, 8'h20, 32'h0, lat, rw, rd, re);
    force_ready = 1'b0;
    check("setup_ready_latency", 32'(lat), 32'd3);
    check("setup_ready_rdata", rd, 32'hA5A5_5A5A);

    // FIFO full with responses blocked: one transfer, then hold in IDLE
    n0 = setup_q.size();
    exp_w = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    exp_d = '{32'h0, 32'h11, 32'h0, 32'h22, 32'h0000_000F};
    push_cmd(1'b1, 8'h40, 32'h11);
    push_cmd(1'b0, 8'h40, 32'h0);
    push_cmd(1'b1, 8'h41, 32'h22);
    push_cmd(1'b0, 8'h41, 32'h0);
    push_cmd(1'b0, ADDR_ENABLES, 32'h0);
    check("full_cmd_ready", 32'(bus.cmd_ready), 32'd0);
    repeat (8) @(posedge clk);
    #1;
    check("full_transfers", 32'(setup_q.size() - n0), 32'd1);
    check("full_rsp_held", 32'(bus.rsp_valid), 32'd1);
    check("full_psel_idle", 32'(bus.PSEL), 32'd0);
    check("full_busy", 32'(busy), 32'd1);

    // Ordered drain with rsp_ready held high
    k = 0;
    check("drain_rsp0_write", 32'(bus.rsp_write), 32'(exp_w[0]));
    check("drain_rsp0_rdata", bus.rsp_rdata, exp_d[0]);
    k = 1;
    bus.rsp_ready = 1'b1;
    g = 0;
    while (k < 5 && g < 100) begin
      @(posedge clk); #1; g++;
      if (bus.rsp_valid) begin
        check($sformatf("drain_rsp%0d_write", k), 32'(bus.rsp_write), 32'(exp_w[k]));
        check($sformatf("drain_rsp%0d_rdata", k), bus.rsp_rdata, exp_d[k]);
        k++;
      end
    end
    check("drain_count", 32'(k), 32'd5);
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    check("drain_transfers", 32'(setup_q.size() - n0), 32'd5);
    for (int i = 2; i < 5; i++) begin
      if (n0 + i < setup_q.size()) begin
        check($sformatf("drain_period%0d", i), 32'(setup_q[n0+i] - setup_q[n0+i-1]), 32'd4);
        check($sformatf("drain_psel_gap%0d", i), 32'(low_q[n0+i] >= 1), 32'd1);
      end
    end

    // Slow slave: five low-PREADY ACCESS cycles, bus held stable
    wait_st = 5;
    push_cmd(1'b1, 8'h50, 32'hDEAD_BEEF);
    acc = 0;
    saw_rsp = 1'b0;
    g = 0;
    while (g < 50) begin
      @(posedge clk); #1; g++;
      if (bus.PSEL && bus.PENABLE) begin
        acc++;
        check($sformatf("slow_paddr%0d", acc), 32'(bus.PADDR), 32'h50);
        check($sformatf("slow_pwdata%0d", acc), bus.PWDATA, 32'hDEAD_BEEF);
      end else if (acc > 0) begin
        saw_rsp = bus.rsp_valid;
        break;
      end
    end
    check("slow_access_cycles", 32'(acc), 32'd6);
    check("slow_rsp_next_cycle", 32'(saw_rsp), 32'd1);
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    wait_st = 0;

    // Reset while in ACCESS with another command queued
    stall = 1'b1;
    push_cmd(1'b0, ADDR_ENABLES, 32'h0);
    push_cmd(1'b1, 8'h60, 32'h0000_1234);
    g = 0;
    while (!(bus.PSEL && bus.PENABLE) && g < 20) begin
      @(posedge clk); #1; g++;
    end
    check("rst_mid_in_access", 32'(bus.PENABLE), 32'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    stall = 1'b0;
    check("rst_mid_psel", 32'(bus.PSEL), 32'd0);
    check("rst_mid_penable", 32'(bus.PENABLE), 32'd0);
    check("rst_mid_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    check("rst_mid_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_mid_busy", 32'(busy), 32'd0);
    saw_psel = 1'b0;
    saw_rsp = 1'b0;
    repeat (10) begin
      @(posedge clk); #1;
      if (bus.PSEL) saw_psel = 1'b1;
      if (bus.rsp_valid) saw_rsp = 1'b1;
    end
    check("rst_mid_no_transfer", 32'(saw_psel), 32'd0);
    check("rst_mid_no_response", 32'(saw_rsp), 32'd0);
    do_cmd(1'b0, 8'h60, 32'h0, lat, rw, rd, re);
    check("post_rst_latency", 32'(lat), 32'd3);
    check("post_rst_rdata", rd, 32'h0);

`ifdef APB_CFG_TIMEOUT_EN
    // Slave never answers: error response after TMO ACCESS cycles
    stall = 1'b1;
    push_cmd(1'b0, ADDR_ENABLES, 32'h0);
    acc = 0;
    g = 0;
    while (!bus.rsp_valid && g < 100) begin
      @(posedge clk); #1; g++;
      if (bus.PSEL && bus.PENABLE) acc++;
    end
    check("tmo_access_cycles", 32'(acc), 32'(TMO));
    check("tmo_rsp_valid", 32'(bus.rsp_valid), 32'd1);
    check("tmo_rsp_err", 32'(bus.rsp_err), 32'd1);
    check("tmo_rsp_rdata", bus.rsp_rdata, 32'd0);
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    stall = 1'b0;
    do_cmd(1'b0, ADDR_ENABLES, 32'h0, lat, rw, rd, re);
    check("tmo_next_latency", 32'(lat), 32'd3);
    check("tmo_next_rdata", rd, 32'h0000_000F);
    check("tmo_next_err", 32'(re), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
